decode_queue: RTL and testbench

//  Decode stage with a parametrised instruction queue and valid/ready handshakes on both sides.

---
 rtl/decode_queue.sv | 183 ++++++++++++++++++
 tb/tb_decode_queue.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Decode stage: a QDEPTH-entry {instr, pc} FIFO whose head is decoded combinationally into RV32 control signals.
// Optional macro DECODE_EXT_BRANCH_EN adds decoding of BLT, BLTU and BGEU.
module decode_queue #(
  parameter int          XLEN      = 32,
  parameter int          QDEPTH    = 2,
  parameter logic [31:0] NOP_INSTR = 32'h13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            wdSrc_o,
  output logic            regWrite_o,
  output logic            branch_o,
  output logic [2:0]      aluControl_o,
  output logic            aluSrc_o,
  output logic            condZero_o,
  output logic            bge_o,
  output logic            unsigned_o,
  output logic            illegal_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] immI_o,
  output logic [XLEN-1:0] immU_o,
  output logic [XLEN-1:0] pcBranch_o,
  output logic [XLEN-1:0] pcPlus4_o
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_SRL  = 3'd3;
  localparam logic [2:0] ALU_SLTU = 3'd4;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_B   = 7'b1100011;

  logic [31:0]     instrMem_q [QDEPTH];
  logic [XLEN-1:0] pcMem_q    [QDEPTH];
  logic [PW-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full, empty, push, pop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full        = (count_q == CW'(QDEPTH));
  assign empty       = (count_q == '0);
  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign push        = in_valid_i & !full;
  assign pop         = !empty & out_ready_i;

  // Flush wins over any same-cycle push or pop.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = nextPtr(wrPtr_q);
      if (pop)  rdPtr_d = nextPtr(rdPtr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: every output is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush_i) begin
      instrMem_q[wrPtr_q] <= instr_i;
      pcMem_q[wrPtr_q]    <= pc_i;
    end
  end

  logic [31:0]       headInstr;
  logic [XLEN-1:0]   headPc;
  logic signed [11:0] immI12;
  logic signed [31:0] immU32;
  logic signed [12:0] immB13;
  logic [XLEN-1:0]   immIExt, immUExt, immBExt;

  assign headInstr = empty ? NOP_INSTR : instrMem_q[rdPtr_q];
  assign headPc    = empty ? '0 : pcMem_q[rdPtr_q];
  assign immI12    = headInstr[31:20];
  assign immU32    = {headInstr[31:12], 12'b0};
  assign immB13    = {headInstr[31], headInstr[7], headInstr[30:25], headInstr[11:8], 1'b0};
  assign immIExt   = XLEN'(immI12);
  assign immUExt   = XLEN'(immU32);
  assign immBExt   = XLEN'(immB13);

  logic       wdSrcDec, regWriteDec, branchDec, aluSrcDec, condZeroDec, bgeDec, illegalDec;
  logic [2:0] aluControlDec;
`ifdef DECODE_EXT_BRANCH_EN
  logic       unsignedDec;
`endif

  always_comb begin
    wdSrcDec      = 1'b0;
    regWriteDec   = 1'b0;
    branchDec     = 1'b0;
    aluSrcDec     = 1'b0;
    condZeroDec   = 1'b0;
    bgeDec        = 1'b0;
    illegalDec    = 1'b0;
    aluControlDec = ALU_ADD;
`ifdef DECODE_EXT_BRANCH_EN
    unsignedDec   = 1'b0;
`endif
    casez ({headInstr[31:25], headInstr[14:12], headInstr[6:0]})
      {7'b0000000, 3'b000, OP_R}:   regWriteDec = 1'b1;
      {7'b0100000, 3'b000, OP_R}:   begin regWriteDec = 1'b1; aluControlDec = ALU_SUB;  end
      {7'b0000000, 3'b110, OP_R}:   begin regWriteDec = 1'b1; aluControlDec = ALU_OR;   end
      {7'b0000000, 3'b101, OP_R}:   begin regWriteDec = 1'b1; aluControlDec = ALU_SRL;  end
      {7'b0000000, 3'b011, OP_R}:   begin regWriteDec = 1'b1; aluControlDec = ALU_SLTU; end
      {7'b???????, 3'b000, OP_I}:   begin regWriteDec = 1'b1; aluSrcDec = 1'b1; end
      {7'b???????, 3'b???, OP_LUI}: begin regWriteDec = 1'b1; wdSrcDec = 1'b1; end
      {7'b???????, 3'b000, OP_B}:   begin branchDec = 1'b1; aluControlDec = ALU_SUB; condZeroDec = 1'b1; end
      {7'b???????, 3'b001, OP_B}:   begin branchDec = 1'b1; aluControlDec = ALU_SUB; end
      {7'b???????, 3'b101, OP_B}:   begin branchDec = 1'b1; aluControlDec = ALU_SUB; bgeDec = 1'b1; end
`ifdef DECODE_EXT_BRANCH_EN
      {7'b???????, 3'b100, OP_B}:   begin branchDec = 1'b1; aluControlDec = ALU_SUB; end
      {7'b???????, 3'b110, OP_B}:   begin branchDec = 1'b1; aluControlDec = ALU_SUB; unsignedDec = 1'b1; end
      {7'b???????, 3'b111, OP_B}:   begin
        branchDec = 1'b1; aluControlDec = ALU_SUB; bgeDec = 1'b1; unsignedDec = 1'b1;
      end
`endif
      default:                      illegalDec = 1'b1;
    endcase
  end

  assign wdSrc_o      = out_valid_o & wdSrcDec;
  assign regWrite_o   = out_valid_o & regWriteDec;
  assign branch_o     = out_valid_o & branchDec;
  assign aluSrc_o     = out_valid_o & aluSrcDec;
  assign condZero_o   = out_valid_o & condZeroDec;
  assign bge_o        = out_valid_o & bgeDec;
  assign illegal_o    = out_valid_o & illegalDec;
  assign aluControl_o = out_valid_o ? aluControlDec : 3'd0;
`ifdef DECODE_EXT_BRANCH_EN
  assign unsigned_o   = out_valid_o & unsignedDec;
`else
  assign unsigned_o   = 1'b0;
`endif
  assign rs1_o        = out_valid_o ? headInstr[19:15] : 5'd0;
  assign rs2_o        = out_valid_o ? headInstr[24:20] : 5'd0;
  assign rd_o         = out_valid_o ? headInstr[11:7]  : 5'd0;
  assign immI_o       = out_valid_o ? immIExt : '0;
  assign immU_o       = out_valid_o ? immUExt : '0;
  assign pcBranch_o   = out_valid_o ? headPc + immBExt : '0;
  assign pcPlus4_o    = out_valid_o ? headPc + XLEN'(4) : '0;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue: reset, fill, stream, flush and decode scenarios.
module tb_decode_queue;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  localparam logic [31:0] I_ADD  = 32'h00208033;
  localparam logic [31:0] I_SUB  = 32'h40208033;
  localparam logic [31:0] I_OR   = 32'h0020E033;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_BLTU = 32'h0020E463;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid, inReady, flush, outValid, outReady;
  logic [31:0] instr, pc;
  logic        wdSrc, regWrite, branch, aluSrc, condZero, bge, isUnsigned, illegal;
  logic [2:0]  aluControl;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] immI, immU, pcBranch, pcPlus4;

  int passCount = 0;
  int totalCount = 0;

  always #5 clk = ~clk;

  decode_queue #(.XLEN(32), .QDEPTH(2), .NOP_INSTR(32'h13)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(inValid), .in_ready_o(inReady), .instr_i(instr), .pc_i(pc),
    .flush_i(flush), .out_valid_o(outValid), .out_ready_i(outReady),
    .wdSrc_o(wdSrc), .regWrite_o(regWrite), .branch_o(branch), .aluControl_o(aluControl),
    .aluSrc_o(aluSrc), .condZero_o(condZero), .bge_o(bge), .unsigned_o(isUnsigned),
    .illegal_o(illegal), .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
    .immI_o(immI), .immU_o(immU), .pcBranch_o(pcBranch), .pcPlus4_o(pcPlus4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] p,
                               input logic rdy, input logic fl);
    inValid  = v;
    instr    = ins;
    pc       = p;
    outReady = rdy;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    checkOutput("reset out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("reset in_ready", {31'b0, inReady}, 32'd1);
    checkOutput("reset pcPlus4", pcPlus4, 32'd0);
    rst = 1'b0;

    // Fill: two pushes with execute stalled
    applyStimulus(1'b1, I_ADD, 32'h200, 1'b0, 1'b0);
    tick();
    checkOutput("fill1 out_valid", {31'b0, outValid}, 32'd1);
    checkOutput("fill1 in_ready", {31'b0, inReady}, 32'd1);
    checkOutput("fill1 rs1", {27'b0, rs1}, 32'd1);
    checkOutput("fill1 rs2", {27'b0, rs2}, 32'd2);
    checkOutput("fill1 regWrite", {31'b0, regWrite}, 32'd1);
    applyStimulus(1'b1, I_SUB, 32'h204, 1'b0, 1'b0);
    tick();
    checkOutput("fill2 in_ready", {31'b0, inReady}, 32'd0);
    checkOutput("fill2 aluControl", {29'b0, aluControl}, {29'b0, ALU_ADD});
    checkOutput("fill2 pcPlus4", pcPlus4, 32'h204);
    applyStimulus(1'b1, I_OR, 32'h208, 1'b0, 1'b0);
    tick();
    checkOutput("fill3 in_ready", {31'b0, inReady}, 32'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("drain1 aluControl", {29'b0, aluControl}, {29'b0, ALU_SUB});
    checkOutput("drain1 pcPlus4", pcPlus4, 32'h208);
    checkOutput("drain1 in_ready", {31'b0, inReady}, 32'd1);
    tick();
    checkOutput("drain2 out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("drain2 pcPlus4", pcPlus4, 32'd0);

    // Asynchronous reset with one entry queued
    applyStimulus(1'b1, I_ADDI, 32'h300, 1'b0, 1'b0);
    tick();
    checkOutput("addi immI", immI, 32'd5);
    checkOutput("addi aluSrc", {31'b0, aluSrc}, 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("async rst in_ready", {31'b0, inReady}, 32'd1);
    checkOutput("async rst immI", immI, 32'd0);
    checkOutput("async rst regWrite", {31'b0, regWrite}, 32'd0);
    checkOutput("async rst aluSrc", {31'b0, aluSrc}, 32'd0);
    tick();
    rst = 1'b0;

    // Stream: push and pop every cycle, head pc tracks input pc one cycle later
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, I_ADDI & 32'h000F_FFFF | (32'(i) << 20), 32'h400 + 32'(4 * i), 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("stream%0d pcPlus4", i), pcPlus4, 32'h404 + 32'(4 * i));
      checkOutput($sformatf("stream%0d immI", i), immI, 32'(i));
      checkOutput($sformatf("stream%0d in_ready", i), {31'b0, inReady}, 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("stream end out_valid", {31'b0, outValid}, 32'd0);

    // Flush a full queue while fetch also pushes
    applyStimulus(1'b1, I_ADD, 32'h500, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, I_SUB, 32'h504, 1'b0, 1'b0);
    tick();
    checkOutput("preflush in_ready", {31'b0, inReady}, 32'd0);
    applyStimulus(1'b1, I_LUI, 32'h508, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("flush out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("flush in_ready", {31'b0, inReady}, 32'd1);
    tick();
    checkOutput("postflush out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("postflush wdSrc", {31'b0, wdSrc}, 32'd0);

    // Branch and LUI decode
    applyStimulus(1'b1, I_BEQ, 32'h100, 1'b0, 1'b0);
    tick();
    checkOutput("beq branch", {31'b0, branch}, 32'd1);
    checkOutput("beq condZero", {31'b0, condZero}, 32'd1);
    checkOutput("beq aluControl", {29'b0, aluControl}, {29'b0, ALU_SUB});
    checkOutput("beq pcBranch", pcBranch, 32'hFC);
    checkOutput("beq pcPlus4", pcPlus4, 32'h104);
    checkOutput("beq regWrite", {31'b0, regWrite}, 32'd0);
    applyStimulus(1'b1, I_LUI, 32'h110, 1'b1, 1'b0);
    tick();
    checkOutput("lui immU", immU, 32'h12345000);
    checkOutput("lui wdSrc", {31'b0, wdSrc}, 32'd1);
    checkOutput("lui rd", {27'b0, rd}, 32'd1);
    checkOutput("lui illegal", {31'b0, illegal}, 32'd0);
    applyStimulus(1'b1, I_BLTU, 32'h120, 1'b1, 1'b0);
    tick();
`ifdef DECODE_EXT_BRANCH_EN
    checkOutput("bltu branch", {31'b0, branch}, 32'd1);
    checkOutput("bltu unsigned", {31'b0, isUnsigned}, 32'd1);
    checkOutput("bltu bge", {31'b0, bge}, 32'd0);
    checkOutput("bltu illegal", {31'b0, illegal}, 32'd0);
`else
    checkOutput("bltu illegal", {31'b0, illegal}, 32'd1);
    checkOutput("bltu branch", {31'b0, branch}, 32'd0);
    checkOutput("bltu unsigned", {31'b0, isUnsigned}, 32'd0);
`endif
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("illegal pops out_valid", {31'b0, outValid}, 32'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
